// File: rtl/pcie_dn_pkt_buf_if.sv
// Write/read handshake and status bundle for the download packet buffer.
// slave is the buffer's view; master is the DMA/user-logic view.
interface pcie_dn_pkt_buf_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DESC_AW = 6
);
  logic              wr_rdy;
  logic [DATA_W-1:0] wr_data;
  logic              wr_dvld;
  logic              wr_sop;
  logic              wr_eop;
  logic              rd_rdy;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_dvld;
  logic              rd_sop;
  logic              rd_eop;
  logic [ADDR_W:0]   wr_level;
  logic [DESC_AW:0]  burst_cnt;
  logic              ovf_err;

  modport slave (
    input  wr_data, wr_dvld, wr_sop, wr_eop, rd_req,
    output wr_rdy, rd_rdy, rd_data, rd_dvld, rd_sop, rd_eop, wr_level, burst_cnt, ovf_err
  );

  modport master (
    output wr_data, wr_dvld, wr_sop, wr_eop, rd_req,
    input  wr_rdy, rd_rdy, rd_data, rd_dvld, rd_sop, rd_eop, wr_level, burst_cnt, ovf_err
  );
endinterface

// File: rtl/pcie_dn_pkt_buf.sv
// Download packet buffer: word RAM FIFO plus burst descriptor FIFO; user logic
// pulls one whole burst per rd_req. Bursts close on BURST_LEN words or on EOP.
module pcie_dn_pkt_buf #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned DESC_AW      = 6,
  parameter int unsigned AFULL_MARGIN = 256
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clr,
  pcie_dn_pkt_buf_if.slave bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DDEPTH = 2 ** DESC_AW;
  localparam int unsigned BL_W   = $clog2(BURST_LEN + 1);
  localparam int unsigned LW     = ADDR_W + 1;
  localparam int unsigned CW     = DESC_AW + 1;

  typedef struct packed {
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef enum logic {IDLE, RUN} state_t;

  word_t           mem      [DEPTH];
  logic [BL_W-1:0] desc_mem [DDEPTH];

  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [DESC_AW:0] dwr_ptr, drd_ptr;
  logic [BL_W-1:0]  bcnt, bcnt_inc, rem;
  state_t           state, state_nxt;
  word_t            ram_q;
  logic             ram_vld;

  logic          data_full, desc_full, accept, drop, close, pop, ram_rd;
  logic [CW-1:0] burst_cnt_nxt;

  // Extra pointer MSB separates full from empty
  assign data_full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign desc_full = (dwr_ptr[DESC_AW] != drd_ptr[DESC_AW]) &&
                     (dwr_ptr[DESC_AW-1:0] == drd_ptr[DESC_AW-1:0]);

  assign accept   = bus.wr_dvld && !data_full && !desc_full && !clr;
  assign drop     = bus.wr_dvld && (data_full || desc_full) && !clr;
  assign bcnt_inc = bcnt + BL_W'(1);
  assign close    = accept && ((bcnt_inc == BL_W'(BURST_LEN)) || bus.wr_eop);
  assign pop      = (state == IDLE) && bus.rd_req && bus.rd_rdy;
  assign ram_rd   = (state == RUN);

  assign state_nxt     = pop ? RUN : ((ram_rd && (rem == BL_W'(1))) ? IDLE : state);
  assign burst_cnt_nxt = bus.burst_cnt + CW'(close) - CW'(pop);

  // Storage arrays carry no reset so they map onto RAM
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[ADDR_W-1:0]] <= {bus.wr_eop, bus.wr_sop, bus.wr_data};
    if (close)  desc_mem[dwr_ptr[DESC_AW-1:0]] <= bcnt_inc;
    if (ram_rd) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // Pointers, burst tracking, read FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      dwr_ptr       <= '0;
      drd_ptr       <= '0;
      bcnt          <= '0;
      rem           <= '0;
      state         <= IDLE;
      ram_vld       <= 1'b0;
      bus.wr_rdy    <= 1'b1;
      bus.rd_rdy    <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_dvld   <= 1'b0;
      bus.rd_sop    <= 1'b0;
      bus.rd_eop    <= 1'b0;
      bus.wr_level  <= '0;
      bus.burst_cnt <= '0;
      bus.ovf_err   <= 1'b0;
    end else if (clr) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      dwr_ptr       <= '0;
      drd_ptr       <= '0;
      bcnt          <= '0;
      rem           <= '0;
      state         <= IDLE;
      ram_vld       <= 1'b0;
      bus.wr_rdy    <= 1'b1;
      bus.rd_rdy    <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_dvld   <= 1'b0;
      bus.rd_sop    <= 1'b0;
      bus.rd_eop    <= 1'b0;
      bus.wr_level  <= '0;
      bus.burst_cnt <= '0;
      bus.ovf_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + LW'(1);
        bcnt   <= close ? '0 : bcnt_inc;
      end
      if (close)  dwr_ptr <= dwr_ptr + CW'(1);
      if (pop)    drd_ptr <= drd_ptr + CW'(1);
      if (ram_rd) rd_ptr  <= rd_ptr + LW'(1);

      if (pop)         rem <= desc_mem[drd_ptr[DESC_AW-1:0]];
      else if (ram_rd) rem <= rem - BL_W'(1);
      state   <= state_nxt;
      ram_vld <= ram_rd;

      bus.rd_dvld <= ram_vld;
      bus.rd_sop  <= ram_vld & ram_q.sop;
      bus.rd_eop  <= ram_vld & ram_q.eop;
      if (ram_vld) bus.rd_data <= ram_q.data;

      bus.wr_level  <= bus.wr_level + LW'(accept) - LW'(ram_rd);
      bus.burst_cnt <= burst_cnt_nxt;
      bus.wr_rdy    <= ((DEPTH - 32'(bus.wr_level)) >= AFULL_MARGIN) &&
                       ((DDEPTH - 32'(bus.burst_cnt)) >= 32'd2);
      bus.rd_rdy    <= (burst_cnt_nxt != '0) && (state_nxt == IDLE);
      bus.ovf_err   <= bus.ovf_err | drop;
    end
  end
endmodule

// File: tb/tb_pcie_dn_pkt_buf.sv
// Scoreboard bench for pcie_dn_pkt_buf: a queue-based reference model predicts
// occupancy, status flags and every burst read back; a monitor checks the read port.
`timescale 1ns/1ps
module tb_pcie_dn_pkt_buf;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned BURST_LEN    = 16;
  localparam int unsigned DESC_AW      = 7;
  localparam int unsigned AFULL_MARGIN = 256;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DDEPTH = 2 ** DESC_AW;

  typedef logic [DATA_W+1:0] word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  pcie_dn_pkt_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DESC_AW(DESC_AW)) bus ();

  pcie_dn_pkt_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .DESC_AW(DESC_AW), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  word_t data_q[$];
  int    burst_q[$];
  word_t exp_q[$];
  int    exp_start_q[$];
  int    exp_len_q[$];
  int    m_level, m_pending, cur_len, rd_delay, rd_left;
  int    snap_level, snap_pend;
  bit    m_ovf;
  int    cyc;
  int    flush_gen;
  int    n_checks, n_fail;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_w(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_flush();
    data_q.delete(); burst_q.delete(); exp_q.delete();
    exp_start_q.delete(); exp_len_q.delete();
    m_level = 0; m_pending = 0; cur_len = 0; rd_delay = 0; rd_left = 0; m_ovf = 0;
    snap_level = 0; snap_pend = 0;
    flush_gen++;
  endtask

  // One clock: compare status against the model, drive inputs, advance the model
  task automatic cycle(input bit dvld, input bit sop, input bit eop, input bit req, input bit do_clr);
    word_t w;
    bit    exp_wrdy, exp_rrdy;
    int    len;
    exp_wrdy = ((DEPTH - snap_level) >= int'(AFULL_MARGIN)) && ((DDEPTH - snap_pend) >= 2);
    exp_rrdy = (m_pending > 0) && (rd_delay == 0) && (rd_left == 0);
    check_i("wr_level",  int'(bus.wr_level),  m_level);
    check_i("burst_cnt", int'(bus.burst_cnt), m_pending);
    check_i("rd_rdy",    int'(bus.rd_rdy),    int'(exp_rrdy));
    check_i("wr_rdy",    int'(bus.wr_rdy),    int'(exp_wrdy));
    check_i("ovf_err",   int'(bus.ovf_err),   int'(m_ovf));
    snap_level = m_level;
    snap_pend  = m_pending;

    w = {eop, sop, $urandom(), $urandom()};
    bus.wr_dvld = dvld;
    bus.wr_sop  = sop;
    bus.wr_eop  = eop;
    bus.wr_data = w[DATA_W-1:0];
    bus.rd_req  = req;
    clr         = do_clr;

    if (do_clr) begin
      model_flush();
    end else begin
      if (dvld) begin
        if (m_level < DEPTH && m_pending < DDEPTH) begin
          data_q.push_back(w);
          m_level++;
          cur_len++;
          if (cur_len == int'(BURST_LEN) || eop) begin
            burst_q.push_back(cur_len);
            m_pending++;
            cur_len = 0;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (req && exp_rrdy) begin
        len = burst_q.pop_front();
        m_pending--;
        for (int i = 0; i < len; i++) exp_q.push_back(data_q.pop_front());
        exp_start_q.push_back(cyc + 3);
        exp_len_q.push_back(len);
        rd_delay = 1;
        rd_left  = len;
      end
    end

    @(posedge clk);
    #1;
    clr = 1'b0;
    if (rd_delay > 0) rd_delay--;
    else if (rd_left > 0) begin
      rd_left--;
      m_level--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_pending > 0 || rd_left > 0 || rd_delay > 0 || exp_q.size() > 0) && guard < 4000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    check_i("drain_bound", int'(guard < 4000), 1);
    idle(2);
  endtask

  task automatic reset_checks();
    check_i("rst_wr_rdy",    int'(bus.wr_rdy),    1);
    check_i("rst_rd_rdy",    int'(bus.rd_rdy),    0);
    check_i("rst_rd_dvld",   int'(bus.rd_dvld),   0);
    check_w("rst_rd_data",   word_t'(bus.rd_data), '0);
    check_i("rst_wr_level",  int'(bus.wr_level),  0);
    check_i("rst_burst_cnt", int'(bus.burst_cnt), 0);
    check_i("rst_ovf_err",   int'(bus.ovf_err),   0);
  endtask

  // Read-port monitor: start cycle, contiguity/length and word contents
  initial begin
    int    seen_gen;
    bit    in_run;
    int    run_cnt, run_len_exp;
    word_t e;
    seen_gen = 0; in_run = 0; run_cnt = 0; run_len_exp = 0;
    forever begin
      @(negedge clk);
      if (seen_gen != flush_gen || !rst_n) begin
        seen_gen = flush_gen;
        in_run   = 0;
        run_cnt  = 0;
      end else if (bus.rd_dvld) begin
        if (!in_run) begin
          in_run  = 1;
          run_cnt = 0;
          if (exp_start_q.size() == 0) begin
            check_i("rd_unexpected_run", 1, 0);
            run_len_exp = 0;
          end else begin
            check_i("rd_start_cycle", cyc, exp_start_q.pop_front());
            run_len_exp = exp_len_q.pop_front();
          end
        end
        run_cnt++;
        if (exp_q.size() == 0) check_i("rd_unexpected_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_w("rd_word", {bus.rd_eop, bus.rd_sop, bus.rd_data}, e);
        end
      end else if (in_run) begin
        in_run = 0;
        check_i("rd_run_len", run_cnt, run_len_exp);
      end
    end
  end

  initial begin
    #1ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    bus.wr_data = '0; bus.wr_dvld = 1'b0; bus.wr_sop = 1'b0;
    bus.wr_eop  = 1'b0; bus.rd_req = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;

    // 32 words without EOP form two full bursts, read back one per request
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_i("t1_burst_cnt", int'(bus.burst_cnt), 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(17);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Short packet released on EOP
    for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, i == 4, 1'b0, 1'b0);
    check_i("t2_burst_cnt", int'(bus.burst_cnt), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    check_i("t2_rd_rdy_low", int'(bus.rd_rdy), 0);

    // Extra request during RUN is ignored
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    check_i("t4_burst_cnt", int'(bus.burst_cnt), 1);
    drain();

    // Fill to full with no reads; the extra word is dropped
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_i("t3_wr_level", int'(bus.wr_level), DEPTH);
    check_i("t3_ovf_err",  int'(bus.ovf_err),  1);
    check_i("t3_wr_rdy",   int'(bus.wr_rdy),   0);

    // Soft clear mid-burst, with a write in the clear cycle
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_i("t5_rd_dvld",    int'(bus.rd_dvld),   0);
    check_i("t5_wr_level",   int'(bus.wr_level),  0);
    check_i("t5_burst_cnt",  int'(bus.burst_cnt), 0);
    check_i("t5_ovf_err",    int'(bus.ovf_err),   0);
    check_i("t5_wr_rdy",     int'(bus.wr_rdy),    1);
    idle(3);

    // Asynchronous reset in the middle of a packet
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_flush();
    bus.wr_dvld = 1'b0; bus.wr_sop = 1'b0; bus.wr_eop = 1'b0; bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, i == 0, i == 2, 1'b0, 1'b0);
    drain();

    // Randomized packets with random gaps and read requests
    for (int p = 0; p < 60; p++) begin
      int plen;
      plen = int'($urandom_range(1, 40));
      for (int i = 0; i < plen; i++) begin
        while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, 2) == 0, 1'b0);
        cycle(1'b1, i == 0, i == plen - 1, $urandom_range(0, 2) == 0, 1'b0);
      end
    end
    drain();
    check_i("end_wr_level", int'(bus.wr_level), 0);
    check_i("end_rd_rdy",   int'(bus.rd_rdy),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
